// File: rtl/prog_loader_if.sv
// Instruction-memory write port and load status exported by prog_loader.
// The loader drives everything (master); the memory/CPU side only observes (slave).
interface prog_loader_if;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  modport master (
    output mem_wr_en, mem_wr_addr, mem_wr_data,
    output cpu_hold, load_done, load_err
  );

  modport slave (
    input mem_wr_en, mem_wr_addr, mem_wr_data,
    input cpu_hold, load_done, load_err
  );
endinterface

// File: rtl/prog_loader.sv
// UART (8N1) boot loader: receives an A5/count/words/checksum frame and writes
// the words into a 256x32 instruction memory, holding the CPU until a frame checks out.
module prog_loader #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic         clkd,
  input  logic         RESET,
  input  logic         RXD,
  prog_loader_if.master ldr
);

  localparam logic [15:0] LAST_T = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_T = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]  MAGIC  = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {WAIT_MAGIC, GET_COUNT, GET_DATA, GET_CSUM, DONE} ld_state_t;

  rx_state_t   rx_state_reg;
  logic        rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic [15:0] rx_timer_reg;
  logic [2:0]  rx_bit_reg;
  logic [7:0]  rx_shift_reg;

  ld_state_t   ld_state_reg;
  logic [8:0]  words_left_reg;
  logic [7:0]  word_idx_reg;
  logic [1:0]  byte_idx_reg;
  logic [31:0] word_reg;
  logic [7:0]  sum_reg;
  logic        mem_wr_en_reg;
  logic [7:0]  mem_wr_addr_reg;
  logic [31:0] mem_wr_data_reg;
  logic        cpu_hold_reg, load_done_reg, load_err_reg;

  logic        stop_sample, byte_stb, frame_err;
  logic [31:0] word_next;

  // Stop bit is judged in the cycle its timer expires; strobes are combinational in that cycle.
  assign stop_sample = (rx_state_reg == RX_STOP) && (rx_timer_reg == LAST_T);
  assign byte_stb    = stop_sample &&  rx_sync_reg;
  assign frame_err   = stop_sample && !rx_sync_reg;
  assign word_next   = {rx_shift_reg, word_reg[31:8]};

  always_ff @(posedge clkd) begin
    if (!RESET) begin
      rx_meta_reg  <= 1'b1;
      rx_sync_reg  <= 1'b1;
      rx_prev_reg  <= 1'b1;
      rx_state_reg <= RX_IDLE;
      rx_timer_reg <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
    end else begin
      rx_meta_reg <= RXD;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
      case (rx_state_reg)
        RX_IDLE: begin
          // The synced line fell one cycle ago, so the timer starts at 1.
          if (rx_prev_reg && !rx_sync_reg) begin
            rx_state_reg <= RX_START;
            rx_timer_reg <= 16'd1;
          end
        end
        RX_START: begin
          if (rx_timer_reg == HALF_T) begin
            rx_timer_reg <= '0;
            rx_bit_reg   <= '0;
            rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
          end else begin
            rx_timer_reg <= rx_timer_reg + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_timer_reg == LAST_T) begin
            rx_timer_reg <= '0;
            rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
            rx_bit_reg   <= rx_bit_reg + 3'd1;
            if (rx_bit_reg == 3'd7) rx_state_reg <= RX_STOP;
          end else begin
            rx_timer_reg <= rx_timer_reg + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_timer_reg == LAST_T) begin
            rx_timer_reg <= '0;
            rx_state_reg <= RX_IDLE;
          end else begin
            rx_timer_reg <= rx_timer_reg + 16'd1;
          end
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clkd) begin
    if (!RESET) begin
      ld_state_reg    <= WAIT_MAGIC;
      words_left_reg  <= '0;
      word_idx_reg    <= '0;
      byte_idx_reg    <= '0;
      word_reg        <= '0;
      sum_reg         <= '0;
      mem_wr_en_reg   <= 1'b0;
      mem_wr_addr_reg <= '0;
      mem_wr_data_reg <= '0;
      cpu_hold_reg    <= 1'b1;
      load_done_reg   <= 1'b0;
      load_err_reg    <= 1'b0;
    end else begin
      mem_wr_en_reg <= 1'b0;
      if (frame_err) begin
        if (ld_state_reg == GET_COUNT || ld_state_reg == GET_DATA || ld_state_reg == GET_CSUM) begin
          load_err_reg <= 1'b1;
          cpu_hold_reg <= 1'b1;
          ld_state_reg <= WAIT_MAGIC;
        end
      end else if (byte_stb) begin
        case (ld_state_reg)
          WAIT_MAGIC, DONE: begin
            if (rx_shift_reg == MAGIC) begin
              load_err_reg  <= 1'b0;
              load_done_reg <= 1'b0;
              cpu_hold_reg  <= 1'b1;
              sum_reg       <= '0;
              word_idx_reg  <= '0;
              ld_state_reg  <= GET_COUNT;
            end
          end
          GET_COUNT: begin
            words_left_reg <= (rx_shift_reg == 8'd0) ? 9'd256 : {1'b0, rx_shift_reg};
            byte_idx_reg   <= '0;
            ld_state_reg   <= GET_DATA;
          end
          GET_DATA: begin
            word_reg     <= word_next;
            sum_reg      <= sum_reg + rx_shift_reg;
            byte_idx_reg <= byte_idx_reg + 2'd1;
            if (byte_idx_reg == 2'd3) begin
              mem_wr_en_reg   <= 1'b1;
              mem_wr_addr_reg <= word_idx_reg;
              mem_wr_data_reg <= word_next;
              word_idx_reg    <= word_idx_reg + 8'd1;
              words_left_reg  <= words_left_reg - 9'd1;
              if (words_left_reg == 9'd1) ld_state_reg <= GET_CSUM;
            end
          end
          GET_CSUM: begin
            if (rx_shift_reg == sum_reg) begin
              load_done_reg <= 1'b1;
              cpu_hold_reg  <= 1'b0;
              ld_state_reg  <= DONE;
            end else begin
              load_err_reg  <= 1'b1;
              ld_state_reg  <= WAIT_MAGIC;
            end
          end
          default: ld_state_reg <= WAIT_MAGIC;
        endcase
      end
    end
  end

  assign ldr.mem_wr_en   = mem_wr_en_reg;
  assign ldr.mem_wr_addr = mem_wr_addr_reg;
  assign ldr.mem_wr_data = mem_wr_data_reg;
  assign ldr.cpu_hold    = cpu_hold_reg;
  assign ldr.load_done   = load_done_reg;
  assign ldr.load_err    = load_err_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader at 4 clocks per bit: good/bad frames, glitches,
// framing errors, mid-frame reset, and a full 256-word load.
module tb_prog_loader;
  localparam int CPB = 4;

  typedef logic [7:0] byte_q_t[$];

  logic clkd  = 1'b0;
  logic RESET = 1'b0;
  logic RXD   = 1'b1;

  prog_loader_if bus();

  prog_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clkd  (clkd),
    .RESET (RESET),
    .RXD   (RXD),
    .ldr   (bus.master)
  );

  always #5 clkd = ~clkd;

  int passed = 0;
  int total  = 0;

  logic [7:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          double_cnt = 0;
  logic        prev_en = 1'b0;

  // Write log; a strobe high on two consecutive cycles is counted as a violation.
  always @(negedge clkd) begin
    if (bus.mem_wr_en === 1'b1) begin
      wa_q.push_back(bus.mem_wr_addr);
      wd_q.push_back(bus.mem_wr_data);
      if (prev_en) double_cnt++;
    end
    prev_en = (bus.mem_wr_en === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    $display("check %-24s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RXD = bits[i];
      repeat (CPB) @(negedge clkd);
    end
    RXD = 1'b1;
    if (!stop) repeat (2 * CPB) @(negedge clkd);
  endtask

  task automatic send_seq(input byte_q_t seq);
    foreach (seq[i]) send_byte(seq[i], 1'b1);
  endtask

  task automatic check_two_words(input string tag, input int base);
    check({tag, "_nwr"},   32'(wa_q.size() - base), 32'd2);
    check({tag, "_addr0"}, 32'(wa_q[base]),        32'h0);
    check({tag, "_data0"}, wd_q[base],             32'h0000_0013);
    check({tag, "_addr1"}, 32'(wa_q[base + 1]),    32'h1);
    check({tag, "_data1"}, wd_q[base + 1],         32'h0010_0093);
  endtask

  task automatic check_status(input string tag, input logic hold, input logic done, input logic err);
    check({tag, "_hold"}, 32'(bus.cpu_hold),  32'(hold));
    check({tag, "_done"}, 32'(bus.load_done), 32'(done));
    check({tag, "_err"},  32'(bus.load_err),  32'(err));
  endtask

  initial begin
    int base;
    int bad;
    byte_q_t good;
    good = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};

    // Reset values
    repeat (5) @(negedge clkd);
    check_status("rst", 1'b1, 1'b0, 1'b0);
    check("rst_wr_en", 32'(bus.mem_wr_en),   32'd0);
    check("rst_addr",  32'(bus.mem_wr_addr), 32'd0);
    check("rst_data",  bus.mem_wr_data,      32'd0);
    RESET = 1'b1;
    repeat (3) @(negedge clkd);

    // One-cycle glitch while waiting for magic
    base = wa_q.size();
    RXD = 1'b0;
    @(negedge clkd);
    RXD = 1'b1;
    repeat (12 * CPB) @(negedge clkd);
    check("glitch_nwr", 32'(wa_q.size() - base), 32'd0);
    check_status("glitch", 1'b1, 1'b0, 1'b0);

    // Good frame, checking the write strobe lands the cycle after the 4th byte
    base = wa_q.size();
    send_seq('{8'hA5, 8'h02, 8'h13, 8'h00, 8'h00});
    check("pre_wr_en", 32'(bus.mem_wr_en), 32'd0);
    send_byte(8'h00, 1'b1);
    check("wr_strobe_cycle", 32'(bus.mem_wr_en), 32'd1);
    send_seq('{8'h93, 8'h00, 8'h10, 8'h00, 8'hB6});
    check_two_words("good", base);
    check_status("good", 1'b0, 1'b1, 1'b0);

    // In DONE: non-magic ignored, magic restarts immediately
    send_byte(8'h55, 1'b1);
    check_status("done_55", 1'b0, 1'b1, 1'b0);
    send_byte(8'hA5, 1'b1);
    check("restart_hold", 32'(bus.cpu_hold),  32'd1);
    check("restart_done", 32'(bus.load_done), 32'd0);

    // Rest of that frame with a bad checksum
    base = wa_q.size();
    send_seq('{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hBA});
    check_two_words("badcs", base);
    check_status("badcs", 1'b1, 1'b0, 1'b1);

    base = wa_q.size();
    send_seq(good);
    check_two_words("recover", base);
    check_status("recover", 1'b0, 1'b1, 1'b0);

    // Framing error after magic and count
    base = wa_q.size();
    send_seq('{8'hA5, 8'h02});
    send_byte(8'h13, 1'b0);
    check("ferr_nwr", 32'(wa_q.size() - base), 32'd0);
    check_status("ferr", 1'b1, 1'b0, 1'b1);
    base = wa_q.size();
    send_seq(good);
    check_two_words("after_ferr", base);
    check_status("after_ferr", 1'b0, 1'b1, 1'b0);

    // Reset after 6 data bytes: one word written, partial word discarded
    base = wa_q.size();
    send_seq('{8'hA5, 8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 8'h55, 8'h66});
    RESET = 1'b0;
    repeat (3) @(negedge clkd);
    check("mrst_nwr",   32'(wa_q.size() - base), 32'd1);
    check("mrst_word",  wd_q[base],              32'h1122_3344);
    check_status("mrst", 1'b1, 1'b0, 1'b0);
    check("mrst_wr_en", 32'(bus.mem_wr_en),   32'd0);
    check("mrst_addr",  32'(bus.mem_wr_addr), 32'd0);
    check("mrst_data",  bus.mem_wr_data,      32'd0);
    RESET = 1'b1;
    repeat (3) @(negedge clkd);
    check("mrst_quiet", 32'(wa_q.size() - base), 32'd1);
    base = wa_q.size();
    send_seq(good);
    check_two_words("after_mrst", base);
    check_status("after_mrst", 1'b0, 1'b1, 1'b0);

    // Count 0 means 256 words
    base = wa_q.size();
    send_seq('{8'hA5, 8'h00});
    for (int i = 0; i < 1024; i++) send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    check("full_nwr", 32'(wa_q.size() - base), 32'd256);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (wa_q[base + i] !== 8'(i) || wd_q[base + i] !== 32'h0101_0101) bad++;
    end
    check("full_contents_bad", 32'(bad), 32'd0);
    check_status("full", 1'b0, 1'b1, 1'b0);

    check("double_strobes", 32'(double_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
